// File: rtl/phy_pkg.sv
// Shared symbol codes, word width and lane state type for the N-lane receiver.
package phy_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [BYTE_W-1:0] COM = 8'hBC;
    localparam logic [BYTE_W-1:0] IDL = 8'h7C;

    typedef enum logic {
        SEARCH = 1'b0,
        ACTIVE = 1'b1
    } lane_state_e;

    // COM and IDL carry no payload once a lane is locked.
    function automatic logic is_ctrl(input logic [BYTE_W-1:0] b);
        return (b == COM) || (b == IDL);
    endfunction

endpackage

// File: rtl/rx_lane.sv
// One receive lane: deserialise, COM alignment, lock FSM, byte packing, 2-entry word FIFO.
module rx_lane
    import phy_pkg::*;
#(
    parameter int unsigned COM_CNT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              serial_i,
    input  logic              link_up_i,
    input  logic              pop_i,
    output logic              active_o,
    output logic              overflow_o,
    output logic              lock_c_o,
    output logic              empty_c_o,
    output logic [WORD_W-1:0] head_c_o
);

    localparam int unsigned CNT_W = $clog2(COM_CNT + 1);

    lane_state_e        state_q, state_d;
    logic [BYTE_W-1:0]  shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   com_cnt_q, com_cnt_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic               byte_vld_q, byte_vld_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [1:0]         word_cnt_q, word_cnt_d;
    logic               word_vld_q, word_vld_d;
    logic               active_q, active_d;
    logic               boundary_c;

    logic [WORD_W-1:0]  mem_q [2];
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic [1:0]         fcnt_q, fcnt_d;
    logic               ovf_q, ovf_d;
    logic               push_c, pop_ok_c, full_c, push_ok_c;

    // Lane state and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SEARCH;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            word_q     <= '0;
            word_cnt_q <= '0;
            word_vld_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
            word_vld_q <= word_vld_d;
            active_q   <= active_d;
        end
    end

    // Next state: shift, byte boundary, lock FSM, byte stage, word packing.
    always_comb begin
        state_d    = state_q;
        com_cnt_d  = com_cnt_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        word_vld_d = 1'b0;

        shift_d = {shift_q[BYTE_W-2:0], serial_i};

        // While searching, a COM in the window realigns the byte boundary to this clock.
        boundary_c = (bit_cnt_q == 3'd7) || ((state_q == SEARCH) && (shift_d == COM));
        bit_cnt_d  = boundary_c ? 3'd0 : bit_cnt_q + 3'd1;

        if (boundary_c) begin
            case (state_q)
                SEARCH: begin
                    if (shift_d == COM) begin
                        if (com_cnt_q == CNT_W'(COM_CNT - 1)) begin
                            state_d   = ACTIVE;
                            com_cnt_d = '0;
                        end else begin
                            com_cnt_d = com_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        com_cnt_d = '0;
                    end
                end
                ACTIVE: begin
                    byte_d     = shift_d;
                    byte_vld_d = 1'b1;
                end
                default: state_d = SEARCH;
            endcase
        end

        // Control bytes abort a partial word; data bytes fill from [31:24] down.
        if (byte_vld_q) begin
            if (is_ctrl(byte_q)) begin
                word_cnt_d = '0;
            end else begin
                word_d = {word_q[WORD_W-BYTE_W-1:0], byte_q};
                if (word_cnt_q == 2'd3) begin
                    word_cnt_d = '0;
                    word_vld_d = 1'b1;
                end else begin
                    word_cnt_d = word_cnt_q + 2'd1;
                end
            end
        end

        active_d = (state_q == ACTIVE);
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_q] <= word_q;
            end
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fcnt_q <= fcnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // FIFO control: a pop in the same clock frees room for a push into a full FIFO.
    always_comb begin
        push_c    = word_vld_q & link_up_i;
        pop_ok_c  = pop_i & (fcnt_q != 2'd0);
        full_c    = (fcnt_q == 2'd2);
        push_ok_c = push_c & (~full_c | pop_ok_c);

        wr_d   = push_ok_c ? ~wr_q : wr_q;
        rd_d   = pop_ok_c ? ~rd_q : rd_q;
        fcnt_d = fcnt_q;
        if (push_ok_c && !pop_ok_c) begin
            fcnt_d = fcnt_q + 2'd1;
        end else if (!push_ok_c && pop_ok_c) begin
            fcnt_d = fcnt_q - 2'd1;
        end
        ovf_d = ovf_q | (push_c & full_c & ~pop_ok_c);
    end

    assign active_o   = active_q;
    assign overflow_o = ovf_q;
    assign lock_c_o   = active_d;
    assign empty_c_o  = (fcnt_q == 2'd0);
    assign head_c_o   = mem_q[rd_q];

endmodule

// File: rtl/phy_rx_nlane.sv
// N-lane serial receiver top: per-lane receivers plus round-robin destriping.
module phy_rx_nlane
    import phy_pkg::*;
#(
    parameter int unsigned LANES   = 2,
    parameter int unsigned COM_CNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [LANES-1:0]  data_serial,
    output logic [LANES-1:0]  active,
    output logic              link_up,
    output logic [WORD_W-1:0] data_output,
    output logic              valid_out,
    output logic [LANES-1:0]  overflow
);

    localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]  lock_c;
    logic [LANES-1:0]  empty_c;
    logic [LANES-1:0]  pop_c;
    logic [WORD_W-1:0] head_c [LANES];

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              link_up_q, link_up_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        rx_lane #(
            .COM_CNT (COM_CNT)
        ) u_lane (
            .clk_i      (clk_32f),
            .rst_i      (reset),
            .serial_i   (data_serial[g]),
            .link_up_i  (link_up_q),
            .pop_i      (pop_c[g]),
            .active_o   (active[g]),
            .overflow_o (overflow[g]),
            .lock_c_o   (lock_c[g]),
            .empty_c_o  (empty_c[g]),
            .head_c_o   (head_c[g])
        );
    end

    // Destriping output and pointer registers.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            link_up_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            link_up_q <= link_up_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    // Pop strictly in lane order; an empty lane stalls the pointer.
    always_comb begin
        pop_c     = '0;
        ptr_d     = ptr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        link_up_d = &lock_c;

        if (!empty_c[ptr_q]) begin
            pop_c[ptr_q] = 1'b1;
            valid_d      = 1'b1;
            data_d       = head_c[ptr_q];
            ptr_d        = (ptr_q == PTR_W'(LANES - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    assign link_up     = link_up_q;
    assign data_output = data_q;
    assign valid_out   = valid_q;

endmodule

// File: tb/tb_phy_rx_nlane.sv
// Directed bench for phy_rx_nlane with two lanes: vector table plus corner-case sequences.
module tb_phy_rx_nlane;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic [1:0]  data_serial;
    logic [1:0]  active;
    logic        link_up;
    logic [31:0] data_output;
    logic        valid_out;
    logic [1:0]  overflow;

    always #5 clk_32f = ~clk_32f;

    phy_rx_nlane #(
        .LANES   (2),
        .COM_CNT (4)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_serial (data_serial),
        .active      (active),
        .link_up     (link_up),
        .data_output (data_output),
        .valid_out   (valid_out),
        .overflow    (overflow)
    );

    int unsigned cyc = 0;
    always @(posedge clk_32f) cyc <= cyc + 1;

    // Output capture, away from the active edge.
    logic [31:0] got_q[$];
    int unsigned got_cyc[$];
    int unsigned act0_rise = 0;
    logic        act0_prev = 1'b0;
    always @(negedge clk_32f) begin
        if (valid_out === 1'b1) begin
            got_q.push_back(data_output);
            got_cyc.push_back(cyc);
        end
        if (active[0] === 1'b1 && act0_prev !== 1'b1) act0_rise = cyc;
        act0_prev = active[0];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    bit q0[$];
    bit q1[$];

    task automatic put_both(input logic [7:0] b0, input logic [7:0] b1);
        for (int k = 7; k >= 0; k--) begin
            q0.push_back(b0[k]);
            q1.push_back(b1[k]);
        end
    endtask

    task automatic put_one(input int lane, input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            if (lane == 0) q0.push_back(b[k]);
            else           q1.push_back(b[k]);
        end
    endtask

    task automatic play_n(input int n);
        bit b0, b1;
        for (int i = 0; i < n; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            b0 = (q0.size() != 0) ? q0.pop_front() : 1'b0;
            b1 = (q1.size() != 0) ? q1.pop_front() : 1'b0;
            data_serial = {b1, b0};
            @(posedge clk_32f);
            #1;
        end
        data_serial = 2'b00;
    endtask

    task automatic play();
        play_n(100000);
    endtask

    task automatic do_reset();
        data_serial = 2'b00;
        reset = 1'b1;
        repeat (3) @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    task automatic lock_both(input string name);
        for (int i = 0; i < 4; i++) put_both(COM, COM);
        put_both(IDL, IDL);
        play();
        chk({name, "_link_up"}, 32'(link_up), 32'd1);
    endtask

    typedef struct {
        logic [63:0] s0;
        logic [63:0] s1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t        tbl[5];
    int unsigned base;
    int unsigned t0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{64'h11223344_7C7C7C7C, 64'h55667788_7C7C7C7C, 32'h11223344, 32'h55667788};
        tbl[1] = '{64'hAABB7C01_0203047C, 64'h7C7C7C05_0607087C, 32'h01020304, 32'h05060708};
        tbl[2] = '{64'hDEADBEEF_7C7C7C7C, 64'h00000000_7C7C7C7C, 32'hDEADBEEF, 32'h00000000};
        tbl[3] = '{64'hFFFFFFFF_7C7C7C7C, 64'h01234567_7C7C7C7C, 32'hFFFFFFFF, 32'h01234567};
        tbl[4] = '{64'h12BCA1B2_C3D47C7C, 64'h7C13579B_DF7C7C7C, 32'hA1B2C3D4, 32'h13579BDF};

        reset = 1'b0;
        data_serial = 2'b00;
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk_32f);
        #1;
        chk("rst_active",   32'(active),      32'd0);
        chk("rst_link_up",  32'(link_up),     32'd0);
        chk("rst_valid",    32'(valid_out),   32'd0);
        chk("rst_data",     data_output,      32'd0);
        chk("rst_overflow", 32'(overflow),    32'd0);
        reset = 1'b0;

        // Aligned lock, then table of word pairs.
        lock_both("lock0");
        chk("lock0_active", 32'(active), 32'd3);
        for (int r = 0; r < 5; r++) begin
            base = got_q.size();
            t0   = cyc;
            for (int k = 0; k < 8; k++) begin
                put_both(tbl[r].s0[63-8*k -: 8], tbl[r].s1[63-8*k -: 8]);
            end
            play();
            chk($sformatf("row%0d_count", r), got_q.size() - base, 32'd2);
            if (got_q.size() >= base + 2) begin
                chk($sformatf("row%0d_word0", r), got_q[base],     tbl[r].e0);
                chk($sformatf("row%0d_word1", r), got_q[base + 1], tbl[r].e1);
                if (r == 0) begin
                    chk("row0_latency0", got_cyc[base],     t0 + 35);
                    chk("row0_latency1", got_cyc[base + 1], t0 + 36);
                end
            end
            chk($sformatf("row%0d_valid_low", r), 32'(valid_out), 32'd0);
            chk($sformatf("row%0d_hold", r), data_output, tbl[r].e1);
        end

        // Lane 0 offset by three bits before its COMs.
        do_reset();
        chk("shift_rst_active", 32'(active), 32'd0);
        for (int i = 0; i < 3; i++) q0.push_back(1'b0);
        for (int i = 0; i < 4; i++) put_both(COM, COM);
        put_both(8'h11, 8'h55);
        put_both(8'h22, 8'h66);
        put_both(8'h33, 8'h77);
        put_both(8'h44, 8'h88);
        put_both(IDL, IDL);
        put_one(1, IDL);
        base = got_q.size();
        t0   = cyc;
        play();
        chk("shift_act0_rise", act0_rise, t0 + 36);
        chk("shift_count", got_q.size() - base, 32'd2);
        if (got_q.size() >= base + 2) begin
            chk("shift_word0", got_q[base],     32'h11223344);
            chk("shift_word1", got_q[base + 1], 32'h55667788);
            chk("shift_cyc0",  got_cyc[base],   t0 + 70);
        end

        // Interrupted COM run on lane 0.
        do_reset();
        put_both(COM, COM);
        put_both(COM, COM);
        put_both(8'h00, COM);
        put_both(COM, COM);
        put_both(COM, COM);
        put_both(COM, COM);
        play();
        chk("comrun_active_3", 32'(active), 32'd2);
        chk("comrun_link_3",   32'(link_up), 32'd0);
        put_both(COM, COM);
        play();
        chk("comrun_active_edge", 32'(active[0]), 32'd0);
        put_both(IDL, IDL);
        play_n(1);
        chk("comrun_active_4", 32'(active), 32'd3);
        chk("comrun_link_4",   32'(link_up), 32'd1);
        play();

        // Lane 1 silent while lane 0 floods its FIFO.
        do_reset();
        lock_both("ovf_lock");
        base = got_q.size();
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) put_both(8'((w + 1) * 16 + k), IDL);
        end
        put_both(IDL, IDL);
        play();
        chk("ovf_count1",   got_q.size() - base, 32'd1);
        if (got_q.size() >= base + 1) chk("ovf_word_w1", got_q[base], 32'h10111213);
        chk("ovf_flag",     32'(overflow), 32'd1);
        chk("ovf_valid_low", 32'(valid_out), 32'd0);
        put_both(IDL, 8'h50);
        put_both(IDL, 8'h51);
        put_both(IDL, 8'h52);
        put_both(IDL, 8'h53);
        put_both(IDL, IDL);
        play();
        chk("ovf_count3", got_q.size() - base, 32'd3);
        if (got_q.size() >= base + 3) begin
            chk("ovf_word_lane1", got_q[base + 1], 32'h50515253);
            chk("ovf_word_w2",    got_q[base + 2], 32'h20212223);
        end
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset pulsed mid-word.
        put_both(8'h99, 8'h98);
        put_both(8'h97, 8'h96);
        play();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_active",   32'(active),    32'd0);
        chk("midrst_link_up",  32'(link_up),   32'd0);
        chk("midrst_valid",    32'(valid_out), 32'd0);
        chk("midrst_data",     data_output,    32'd0);
        chk("midrst_overflow", 32'(overflow),  32'd0);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        base = got_q.size();
        put_both(8'h11, 8'h11);
        put_both(8'h22, 8'h22);
        put_both(8'h33, 8'h33);
        put_both(8'h44, 8'h44);
        put_both(IDL, IDL);
        play();
        chk("midrst_nolock_active", 32'(active), 32'd0);
        chk("midrst_nolock_count",  got_q.size() - base, 32'd0);
        lock_both("relock");
        put_both(8'h0A, 8'h0E);
        put_both(8'h0B, 8'h0F);
        put_both(8'h0C, 8'h10);
        put_both(8'h0D, 8'h11);
        put_both(IDL, IDL);
        play();
        chk("relock_count", got_q.size() - base, 32'd2);
        if (got_q.size() >= base + 2) begin
            chk("relock_word0", got_q[base],     32'h0A0B0C0D);
            chk("relock_word1", got_q[base + 1], 32'h0E0F1011);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
